// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and a debug/loader port.
// CPU has priority; debug wins after STARVE_LIMIT consecutive lost arbitrations.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          dbg_ack_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic [31:0]   stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, CPU_BUSY, DBG_BUSY} state_e;

  state_e        state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic          cpu_grant, dbg_grant;
  logic          cpu_done, dbg_done;
  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;
  logic          dbg_ack_q;
  logic [31:0]   stall_cnt_q;

  // Grants are only ever issued from IDLE, so every access passes through one IDLE cycle.
  assign cpu_grant = (state_q == IDLE) && cpu_req_i &&
                     (!dbg_req_i || (starve_q < 4'(STARVE_LIMIT)));
  assign dbg_grant = (state_q == IDLE) && dbg_req_i && !cpu_grant;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_grant) begin
          state_d = CPU_BUSY;
          if (dbg_req_i && (starve_q != 4'hF)) starve_d = starve_q + 4'd1;
        end else if (dbg_grant) begin
          state_d  = DBG_BUSY;
          starve_d = '0;
        end
      end
      CPU_BUSY: if (mem_ack_i) state_d = IDLE;
      DBG_BUSY: if (mem_ack_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_done    = (state_q == CPU_BUSY) && mem_ack_i;
    dbg_done    = (state_q == DBG_BUSY) && mem_ack_i;
    cpu_stall_o = cpu_req_i && !cpu_done;
    // Load data bypasses the register so EXMEM/MEMWB capture it on the completing edge.
    cpu_rdata_o = (cpu_done && !mem_we_q) ? mem_rdata_i : cpu_rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      dbg_ack_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (cpu_grant) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= cpu_we_i;
        mem_addr_q  <= cpu_addr_i;
        mem_wdata_q <= cpu_wdata_i;
      end else if (dbg_grant) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= dbg_we_i;
        mem_addr_q  <= dbg_addr_i;
        mem_wdata_q <= dbg_wdata_i;
      end else if (cpu_done || dbg_done) begin
        mem_req_q <= 1'b0;
      end
      if (cpu_done && !mem_we_q) cpu_rdata_q <= mem_rdata_i;
      if (dbg_done && !mem_we_q) dbg_rdata_q <= mem_rdata_i;
      dbg_ack_q <= dbg_done;
      if (cpu_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign dbg_rdata_o = dbg_rdata_q;
  assign dbg_ack_o   = dbg_ack_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a small memory model answers requests with a
// programmable latency, and a negedge monitor checks every memory, CPU and debug completion.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata_o, dbg_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i, stall_cnt_o;
  logic        cpu_stall_o, dbg_ack_o, mem_req_o, mem_we_o, mem_ack_i;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
  } mem_exp_t;

  typedef struct {
    logic [31:0] rdata;
    int          stalls;
  } cpu_exp_t;

  mem_exp_t    mem_q[$];
  cpu_exp_t    cpu_q[$];
  logic [31:0] dbg_q[$];
  mem_exp_t    mon_m;
  cpu_exp_t    mon_c;
  logic [31:0] mon_d;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: ack in the lat-th cycle of mem_req_o; force_ack drives a stray ack while idle.
  logic [31:0] mem [16];
  int          lat = 1;
  logic        force_ack = 1'b0;
  int          mcnt = 0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h7;
    mem[1] = 32'hDEAD_0004;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_o) begin
        mcnt++;
        if (mcnt == lat) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) begin
            mem[mem_addr_o[5:2]] = mem_wdata_o;
            mem_rdata_i = 32'hBAD0_BAD0;
          end else begin
            mem_rdata_i = mem[mem_addr_o[5:2]];
          end
        end else begin
          mem_ack_i   = 1'b0;
          mem_rdata_i = 32'h0;
        end
      end else begin
        mcnt        = 0;
        mem_ack_i   = force_ack;
        mem_rdata_i = 32'h0;
      end
    end
  end

  int req_run = 0;
  int stall_run = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_run   = 0;
      stall_run = 0;
    end else begin
      if (mem_req_o) req_run++; else req_run = 0;
      if (cpu_stall_o) stall_run++;
      if (mem_req_o && mem_ack_i) begin
        if (mem_q.size() == 0) chk("mem_unexpected", 32'd1, 32'd0);
        else begin
          mon_m = mem_q.pop_front();
          chk("mem_we", {31'b0, mem_we_o}, {31'b0, mon_m.we});
          chk("mem_addr", mem_addr_o, mon_m.addr);
          chk("mem_wdata", mem_wdata_o, mon_m.wdata);
          chk("mem_lat", 32'(req_run), 32'(mon_m.lat));
        end
        req_run = 0;
      end
      if (cpu_req && !cpu_stall_o) begin
        if (cpu_q.size() == 0) chk("cpu_unexpected", 32'd1, 32'd0);
        else begin
          mon_c = cpu_q.pop_front();
          chk("cpu_rdata", cpu_rdata_o, mon_c.rdata);
          chk("cpu_stalls", 32'(stall_run), 32'(mon_c.stalls));
        end
        stall_run = 0;
      end
      if (!cpu_req) stall_run = 0;
      if (dbg_ack_o) begin
        if (dbg_q.size() == 0) chk("dbg_unexpected", 32'd1, 32'd0);
        else begin
          mon_d = dbg_q.pop_front();
          chk("dbg_rdata", dbg_rdata_o, mon_d);
        end
      end
    end
  end

  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int l, input logic [31:0] exp_rdata, input int exp_stalls);
    bit done;
    lat = l;
    mem_q.push_back('{we, addr, wdata, l});
    cpu_q.push_back('{exp_rdata, exp_stalls});
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_req   = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!cpu_stall_o) done = 1'b1;
    end
    if (!done) chk("cpu_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2;
    cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  acks;
    bit  done;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    cpu_req = 1'b1;
    #1;
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_stall_cnt", stall_cnt_o, 32'd0);
    chk("rst_dbg_ack", {31'b0, dbg_ack_o}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata_o, 32'd0);
    chk("rst_stall_follows_req", {31'b0, cpu_stall_o}, 32'd1);
    cpu_req = 1'b0;
    #1 chk("rst_stall_no_req", {31'b0, cpu_stall_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // CPU load, L=1
    cpu_access(1'b0, 32'h0, 32'h0, 1, 32'h7, 1);
    chk("stall_cnt_load", stall_cnt_o, 32'd1);
    chk("cpu_rdata_held", cpu_rdata_o, 32'h7);

    // CPU store, L=3
    cpu_access(1'b1, 32'h8, 32'd13, 3, 32'h7, 3);
    chk("stall_cnt_store", stall_cnt_o, 32'd4);

    // Debug write alone, L=2
    lat = 2;
    mem_q.push_back('{1'b1, 32'h10, 32'h55, 2});
    dbg_q.push_back(32'h0);
    dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'h55; dbg_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("dbg_ack_cycle", {31'b0, dbg_ack_o}, 32'(k == 3));
      if (k == 3) dbg_req = 1'b0;
    end
    @(posedge clk); #2;
    chk("stall_cnt_dbg", stall_cnt_o, 32'd4);

    // Both held: CPU x4, DBG, CPU x4, DBG, CPU
    lat = 1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        mem_q.push_back('{1'b0, 32'h0, 32'h0, 1});
        cpu_q.push_back('{32'h7, (r == 1 && c == 0) ? 3 : 1});
      end
      mem_q.push_back('{1'b0, 32'h8, 32'h0, 1});
      dbg_q.push_back(32'd13);
    end
    mem_q.push_back('{1'b0, 32'h0, 32'h0, 1});
    cpu_q.push_back('{32'h7, 3});
    cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_req = 1'b1;
    dbg_we = 1'b0; dbg_addr = 32'h8; dbg_wdata = 32'h0; dbg_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 200 && acks < 11; i++) begin
      @(negedge clk);
      if (mem_req_o && mem_ack_i) acks++;
    end
    if (acks < 11) chk("starve_timeout", 32'(acks), 32'd11);
    @(posedge clk); #2;
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("stall_cnt_starve", stall_cnt_o, 32'd17);

    // Reset in the middle of a 4-cycle CPU access
    lat = 4;
    cpu_we = 1'b0; cpu_addr = 32'h4; cpu_wdata = 32'h0; cpu_req = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("mid_rst_mem_addr", mem_addr_o, 32'd0);
    chk("mid_rst_mem_we", {31'b0, mem_we_o}, 32'd0);
    chk("mid_rst_stall_cnt", stall_cnt_o, 32'd0);
    chk("mid_rst_cpu_rdata", cpu_rdata_o, 32'd0);
    chk("mid_rst_dbg_rdata", dbg_rdata_o, 32'd0);
    chk("mid_rst_stall", {31'b0, cpu_stall_o}, 32'd1);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    force_ack = 1'b1;
    @(negedge clk);
    chk("late_ack_mem_req", {31'b0, mem_req_o}, 32'd0);
    force_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_no_grant", {31'b0, mem_req_o}, 32'd0);
    chk("late_ack_dbg_ack", {31'b0, dbg_ack_o}, 32'd0);
    chk("late_ack_stall_cnt", stall_cnt_o, 32'd0);
    @(posedge clk); #2;
    cpu_access(1'b0, 32'h4, 32'h0, 1, 32'hDEAD_0004, 1);
    chk("stall_cnt_fresh", stall_cnt_o, 32'd1);

    repeat (3) @(posedge clk);
    chk("mem_q_left", 32'(mem_q.size()), 32'd0);
    chk("cpu_q_left", 32'(cpu_q.size()), 32'd0);
    chk("dbg_q_left", 32'(dbg_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
